branch_stats_reporter: RTL

Hardware counterpart to the simulation-side accuracy printout: it consumes the per-branch outcome strobe produced by the TAGE top level, keeps cumulative branch and correct-prediction counts, and at every window boundary (default 100000 branches) pushes a report record into a small FIFO. Records drain over a valid/ready handshake to a host or logging port, so hit-rate figures are available on silicon and FPGA builds without a testbench.

---
 rtl/tage_stats_pkg.sv | 19 +
 rtl/branch_stats_reporter_if.sv | 36 +++
 rtl/report_fifo.sv | 61 ++++++
 rtl/branch_stats_reporter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/tage_stats_pkg.sv
// Shared definitions for the branch statistics reporter: default widths and the
// report record layout carried through the report FIFO.
package tage_stats_pkg;

    localparam int DEF_COUNT_WIDTH  = 22;
    localparam int DEF_WINDOW_SIZE  = 100000;
    localparam int DEF_INDEX_WIDTH  = 8;
    localparam int DEF_WINDOW_WIDTH = $clog2(DEF_WINDOW_SIZE + 1);
    localparam int DEF_FIFO_DEPTH   = 2;

    // Record layout at the default widths; the top level re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_INDEX_WIDTH-1:0]  index;
        logic [DEF_WINDOW_WIDTH-1:0] hits;
        logic [DEF_COUNT_WIDTH-1:0]  total;
        logic [DEF_COUNT_WIDTH-1:0]  correct;
    } reportRecord_t;

endpackage

// File: rtl/branch_stats_reporter_if.sv
// Report drain port: a valid/ready stream of window records from the reporter
// (master) to a host or logging consumer (slave).
interface branch_stats_reporter_if
    import tage_stats_pkg::*;
#(
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH
);

    logic                    ReportValid;
    logic                    ReportReady;
    logic [INDEX_WIDTH-1:0]  ReportIndex;
    logic [WINDOW_WIDTH-1:0] ReportWindowHits;
    logic [COUNT_WIDTH-1:0]  ReportTotalBranches;
    logic [COUNT_WIDTH-1:0]  ReportCorrectlyPredicted;

    modport master (
        output ReportValid,
        output ReportIndex,
        output ReportWindowHits,
        output ReportTotalBranches,
        output ReportCorrectlyPredicted,
        input  ReportReady
    );

    modport slave (
        input  ReportValid,
        input  ReportIndex,
        input  ReportWindowHits,
        input  ReportTotalBranches,
        input  ReportCorrectlyPredicted,
        output ReportReady
    );

endinterface

// File: rtl/report_fifo.sv
// Small synchronous FIFO for report records. The head is read straight out of the
// storage registers, so a push into an empty FIFO is visible right after its edge.
module report_fifo
    import tage_stats_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = reportRecord_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     pushData,
    output logic full,
    output logic headValid,
    input  logic headReady,
    output T     headData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic           popFire;
    logic           pushFire;

    assign full      = (count == CNT_W'(DEPTH));
    assign headValid = (count != '0);
    assign headData  = mem[rdPtr];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign popFire  = headValid & headReady;
    assign pushFire = push & (~full | popFire);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pushFire) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushFire, popFire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_stats_reporter.sv
// Cumulative and per-window branch prediction statistics; each closed window pushes a
// snapshot record into a report FIFO drained over a valid/ready port.
module branch_stats_reporter
    import tage_stats_pkg::*;
#(
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int WINDOW_SIZE  = DEF_WINDOW_SIZE,
    parameter int WINDOW_WIDTH = $clog2(WINDOW_SIZE + 1),
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   BranchValid,
    input  logic                   PredictionCorrect,
    output logic [COUNT_WIDTH-1:0] TotalBranches,
    output logic [COUNT_WIDTH-1:0] CorrectlyPredicted,
    output logic                   Overflow,
    branch_stats_reporter_if.master reportBus
);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0]  index;
        logic [WINDOW_WIDTH-1:0] hits;
        logic [COUNT_WIDTH-1:0]  total;
        logic [COUNT_WIDTH-1:0]  correct;
    } windowRecord_t;

    function automatic logic [COUNT_WIDTH-1:0] bumpCount(
        input logic [COUNT_WIDTH-1:0] value,
        input logic                   enable
    );
        return value + COUNT_WIDTH'(enable);
    endfunction

    function automatic logic [WINDOW_WIDTH-1:0] bumpWindow(
        input logic [WINDOW_WIDTH-1:0] value,
        input logic                    enable
    );
        return value + WINDOW_WIDTH'(enable);
    endfunction

    logic [WINDOW_WIDTH-1:0] windowCount;
    logic [WINDOW_WIDTH-1:0] windowHits;
    logic [INDEX_WIDTH-1:0]  windowIndex;

    logic                    hit;
    logic                    windowClose;
    logic [COUNT_WIDTH-1:0]  totalNext;
    logic [COUNT_WIDTH-1:0]  correctNext;
    logic [WINDOW_WIDTH-1:0] hitsNext;
    windowRecord_t           closeRecord;
    windowRecord_t           headRecord;
    logic                    fifoFull;
    logic                    headValid;
    logic                    popFire;
    logic                    dropRecord;

    assign hit         = BranchValid & PredictionCorrect;
    assign totalNext   = bumpCount(TotalBranches, BranchValid);
    assign correctNext = bumpCount(CorrectlyPredicted, hit);
    assign hitsNext    = bumpWindow(windowHits, hit);

    // The branch that fills the last slot closes the window; the record carries post-increment values.
    assign windowClose = BranchValid && (windowCount == WINDOW_WIDTH'(WINDOW_SIZE - 1));

    always_comb begin
        closeRecord         = '0;
        closeRecord.index   = windowIndex;
        closeRecord.hits    = hitsNext;
        closeRecord.total   = totalNext;
        closeRecord.correct = correctNext;
    end

    assign popFire    = headValid & reportBus.ReportReady;
    assign dropRecord = windowClose & fifoFull & ~popFire;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            TotalBranches      <= '0;
            CorrectlyPredicted <= '0;
            windowCount        <= '0;
            windowHits         <= '0;
            windowIndex        <= '0;
            Overflow           <= 1'b0;
        end else begin
            TotalBranches      <= totalNext;
            CorrectlyPredicted <= correctNext;
            if (windowClose) begin
                windowCount <= '0;
                windowHits  <= '0;
                // Index advances even for a dropped record so the consumer can see the gap.
                windowIndex <= windowIndex + INDEX_WIDTH'(1);
            end else begin
                windowCount <= bumpWindow(windowCount, BranchValid);
                windowHits  <= hitsNext;
            end
            if (dropRecord) begin
                Overflow <= 1'b1;
            end
        end
    end

    report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (windowRecord_t)
    ) u_reportFifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (windowClose),
        .pushData  (closeRecord),
        .full      (fifoFull),
        .headValid (headValid),
        .headReady (reportBus.ReportReady),
        .headData  (headRecord)
    );

    assign reportBus.ReportValid              = headValid;
    assign reportBus.ReportIndex              = headRecord.index;
    assign reportBus.ReportWindowHits         = headRecord.hits;
    assign reportBus.ReportTotalBranches      = headRecord.total;
    assign reportBus.ReportCorrectlyPredicted = headRecord.correct;

endmodule
